// File: rtl/mem_stage.sv
// Memory pipeline stage: issues the data-cache access, holds upstream while the cache is busy,
// buffers a result completed under an external freeze, and registers the MEM/WB outputs.
module mem_stage #(
    parameter int BIT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BIT_W-1:0]   alu_result_in,
    input  logic [BIT_W-1:0]   mem_wdata_in,
    input  logic [4:0]         rd_in,
    input  logic [BIT_W-1:0]   PC_step_in,
    input  logic               memrd_in,
    input  logic               memwr_in,
    input  logic               mem2reg_in,
    input  logic               regwr_in,
    input  logic               jump_in,
    input  logic               stall_in,
    output logic               dcache_ren,
    output logic               dcache_wen,
    output logic [BIT_W-3:0]   dcache_addr,
    output logic [BIT_W-1:0]   dcache_wdata,
    input  logic [BIT_W-1:0]   dcache_rdata,
    input  logic               dcache_stall,
    output logic               stall_o,
    output logic [BIT_W-1:0]   wb_data,
    output logic [4:0]         wb_rd,
    output logic               wb_regwr,
    output logic               fwd_valid_o,
    output logic [4:0]         fwd_rd_o,
    output logic [BIT_W-1:0]   fwd_data_o,
    output logic               misalign_o,
    output logic [CNT_W-1:0]   stall_cycles_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              w_acc;
    logic              w_not_hold;
    logic              w_mem_req;
    logic              w_complete;
    logic              w_cache_stall;
    logic              w_misalign;
    logic [BIT_W-1:0]  w_wb_sel;

    logic [BIT_W-1:0]  r_load_buf;
    logic [BIT_W-1:0]  r_wb_data;
    logic [4:0]        r_wb_rd;
    logic              r_wb_regwr;
    logic              r_misalign;
    logic [CNT_W-1:0]  r_stall_cycles;

    // HOLD masks the request so an access finished under freeze is never issued twice
    assign w_acc         = memrd_in | memwr_in;
    assign w_not_hold    = (r_state != ST_HOLD);
    assign w_mem_req     = w_acc & w_not_hold;
    assign w_complete    = w_mem_req & ~dcache_stall;
    assign w_cache_stall = w_mem_req & dcache_stall;
    assign w_misalign    = (alu_result_in[1:0] != 2'b00);

    assign dcache_ren    = memrd_in & w_not_hold;
    assign dcache_wen    = memwr_in & w_not_hold;
    assign dcache_addr   = alu_result_in[BIT_W-1:2];
    assign dcache_wdata  = mem_wdata_in;
    assign stall_o       = w_cache_stall;

    // Loads are excluded: their data is not known until the cache answers
    assign fwd_valid_o   = regwr_in & ~mem2reg_in & (rd_in != 5'd0);
    assign fwd_rd_o      = rd_in;
    assign fwd_data_o    = jump_in ? PC_step_in : alu_result_in;

    assign wb_data        = r_wb_data;
    assign wb_rd          = r_wb_rd;
    assign wb_regwr       = r_wb_regwr;
    assign misalign_o     = r_misalign;
    assign stall_cycles_o = r_stall_cycles;

    // Access state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for the outstanding / buffered access
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cache_stall) begin
                    w_state_nxt = ST_REQ;
                end else if (w_complete && stall_in) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (w_complete) begin
                    w_state_nxt = stall_in ? ST_HOLD : ST_IDLE;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (!stall_in) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write-back data select; a buffered load wins over the live cache bus while in HOLD
    always_comb begin
        w_wb_sel = alu_result_in;
        if (mem2reg_in) begin
            w_wb_sel = (r_state == ST_HOLD) ? r_load_buf : dcache_rdata;
        end else if (jump_in) begin
            w_wb_sel = PC_step_in;
        end else begin
            w_wb_sel = alu_result_in;
        end
    end

    // Capture load data that completes while the pipeline is frozen
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_buf <= {BIT_W{1'b0}};
        end else if (w_complete && stall_in) begin
            r_load_buf <= dcache_rdata;
        end
    end

    // MEM/WB pipeline register: hold on freeze, bubble on cache stall, else advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_data  <= {BIT_W{1'b0}};
            r_wb_rd    <= 5'd0;
            r_wb_regwr <= 1'b0;
        end else if (stall_in) begin
            r_wb_data  <= r_wb_data;
            r_wb_rd    <= r_wb_rd;
            r_wb_regwr <= r_wb_regwr;
        end else if (w_cache_stall) begin
            r_wb_regwr <= 1'b0;
        end else begin
            r_wb_data  <= w_wb_sel;
            r_wb_rd    <= rd_in;
            r_wb_regwr <= regwr_in & (rd_in != 5'd0);
        end
    end

    // One-cycle flag after a misaligned access completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_complete & w_misalign;
        end
    end

    // Saturating count of cache-stall cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= {CNT_W{1'b0}};
        end else if (w_cache_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU, stalled load, frozen store/load,
// jal, misalignment, reset during a request and stall-counter saturation.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_result_in;
    logic [31:0] mem_wdata_in;
    logic [4:0]  rd_in;
    logic [31:0] PC_step_in;
    logic        memrd_in;
    logic        memwr_in;
    logic        mem2reg_in;
    logic        regwr_in;
    logic        jump_in;
    logic        stall_in;
    logic        dcache_ren;
    logic        dcache_wen;
    logic [29:0] dcache_addr;
    logic [31:0] dcache_wdata;
    logic [31:0] dcache_rdata;
    logic        dcache_stall;
    logic        stall_o;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_regwr;
    logic        fwd_valid_o;
    logic [4:0]  fwd_rd_o;
    logic [31:0] fwd_data_o;
    logic        misalign_o;
    logic [15:0] stall_cycles_o;

    int total;
    int bad;
    int wen_cnt;

    mem_stage #(.BIT_W(32), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_result_in  (alu_result_in),
        .mem_wdata_in   (mem_wdata_in),
        .rd_in          (rd_in),
        .PC_step_in     (PC_step_in),
        .memrd_in       (memrd_in),
        .memwr_in       (memwr_in),
        .mem2reg_in     (mem2reg_in),
        .regwr_in       (regwr_in),
        .jump_in        (jump_in),
        .stall_in       (stall_in),
        .dcache_ren     (dcache_ren),
        .dcache_wen     (dcache_wen),
        .dcache_addr    (dcache_addr),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_stall   (dcache_stall),
        .stall_o        (stall_o),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .wb_regwr       (wb_regwr),
        .fwd_valid_o    (fwd_valid_o),
        .fwd_rd_o       (fwd_rd_o),
        .fwd_data_o     (fwd_data_o),
        .misalign_o     (misalign_o),
        .stall_cycles_o (stall_cycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr();
        alu_result_in = 32'h0;
        mem_wdata_in  = 32'h0;
        rd_in         = 5'd0;
        PC_step_in    = 32'h0;
        memrd_in      = 1'b0;
        memwr_in      = 1'b0;
        mem2reg_in    = 1'b0;
        regwr_in      = 1'b0;
        jump_in       = 1'b0;
        stall_in      = 1'b0;
        dcache_rdata  = 32'h0;
        dcache_stall  = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        clr();
        tick();
        tick();
        chk("rst_wb_data",  wb_data, 32'h0);
        chk("rst_wb_rd",    32'(wb_rd), 32'h0);
        chk("rst_wb_regwr", 32'(wb_regwr), 32'h0);
        chk("rst_misalign", 32'(misalign_o), 32'h0);
        chk("rst_cnt",      32'(stall_cycles_o), 32'h0);
        chk("rst_stall_o",  32'(stall_o), 32'h0);
        rst_n = 1'b1;

        // ALU op with forwarding
        alu_result_in = 32'h1234; regwr_in = 1'b1; rd_in = 5'd5;
        settle();
        chk("alu_fwd_valid", 32'(fwd_valid_o), 32'h1);
        chk("alu_fwd_data",  fwd_data_o, 32'h1234);
        chk("alu_fwd_rd",    32'(fwd_rd_o), 32'h5);
        tick();
        chk("alu_wb_data",  wb_data, 32'h1234);
        chk("alu_wb_rd",    32'(wb_rd), 32'h5);
        chk("alu_wb_regwr", 32'(wb_regwr), 32'h1);

        // Load with three cache-stall cycles
        clr();
        memrd_in = 1'b1; mem2reg_in = 1'b1; regwr_in = 1'b1; rd_in = 5'd7;
        alu_result_in = 32'h100; dcache_stall = 1'b1;
        settle();
        chk("ld_ren",       32'(dcache_ren), 32'h1);
        chk("ld_addr",      32'(dcache_addr), 32'h40);
        chk("ld_fwd_valid", 32'(fwd_valid_o), 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("ld_stall_o", 32'(stall_o), 32'h1);
            tick();
            chk("ld_bubble_regwr", 32'(wb_regwr), 32'h0);
            chk("ld_hold_data",    wb_data, 32'h1234);
        end
        dcache_stall = 1'b0; dcache_rdata = 32'hCAFEBABE;
        settle();
        chk("ld_stall_o_low", 32'(stall_o), 32'h0);
        tick();
        chk("ld_wb_data",  wb_data, 32'hCAFEBABE);
        chk("ld_wb_rd",    32'(wb_rd), 32'h7);
        chk("ld_wb_regwr", 32'(wb_regwr), 32'h1);
        chk("ld_cnt",      32'(stall_cycles_o), 32'h3);

        // Plain ALU op to give the MEM/WB register a distinctive value
        clr();
        alu_result_in = 32'h55; rd_in = 5'd3; regwr_in = 1'b1;
        tick();
        chk("pre_st_wb_data", wb_data, 32'h55);

        // Store completing under a four-cycle freeze
        clr();
        memwr_in = 1'b1; alu_result_in = 32'h200; mem_wdata_in = 32'hDEADBEEF;
        rd_in = 5'd2; stall_in = 1'b1;
        settle();
        chk("st_wdata", dcache_wdata, 32'hDEADBEEF);
        chk("st_addr",  32'(dcache_addr), 32'h80);
        wen_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (dcache_wen) wen_cnt = wen_cnt + 1;
            chk("st_stall_o", 32'(stall_o), 32'h0);
            tick();
            chk("st_hold_data",  wb_data, 32'h55);
            chk("st_hold_rd",    32'(wb_rd), 32'h3);
            chk("st_hold_regwr", 32'(wb_regwr), 32'h1);
        end
        stall_in = 1'b0;
        settle();
        if (dcache_wen) wen_cnt = wen_cnt + 1;
        chk("st_wen_once", 32'(wen_cnt), 32'h1);
        tick();
        chk("st_wb_data",  wb_data, 32'h200);
        chk("st_wb_regwr", 32'(wb_regwr), 32'h0);

        // Load completing under freeze; cache bus changes afterwards
        clr();
        memrd_in = 1'b1; mem2reg_in = 1'b1; regwr_in = 1'b1; rd_in = 5'd9;
        alu_result_in = 32'h300; dcache_rdata = 32'hA5A5A5A5; stall_in = 1'b1;
        tick();
        dcache_rdata = 32'h0;
        settle();
        chk("lf_ren_masked", 32'(dcache_ren), 32'h0);
        chk("lf_hold_data",  wb_data, 32'h200);
        tick();
        stall_in = 1'b0;
        tick();
        chk("lf_wb_data",  wb_data, 32'hA5A5A5A5);
        chk("lf_wb_rd",    32'(wb_rd), 32'h9);
        chk("lf_wb_regwr", 32'(wb_regwr), 32'h1);

        // jal, then jal to x0
        clr();
        jump_in = 1'b1; PC_step_in = 32'h208; alu_result_in = 32'h999;
        rd_in = 5'd1; regwr_in = 1'b1;
        settle();
        chk("jal_fwd_data",  fwd_data_o, 32'h208);
        chk("jal_fwd_valid", 32'(fwd_valid_o), 32'h1);
        tick();
        chk("jal_wb_data",  wb_data, 32'h208);
        chk("jal_wb_regwr", 32'(wb_regwr), 32'h1);
        rd_in = 5'd0;
        settle();
        chk("jal0_fwd_valid", 32'(fwd_valid_o), 32'h0);
        tick();
        chk("jal0_wb_regwr", 32'(wb_regwr), 32'h0);
        chk("jal0_wb_data",  wb_data, 32'h208);

        // Misaligned load with one stall cycle
        clr();
        memrd_in = 1'b1; mem2reg_in = 1'b1; regwr_in = 1'b1; rd_in = 5'd4;
        alu_result_in = 32'h102; dcache_stall = 1'b1; dcache_rdata = 32'h11;
        settle();
        chk("mis_addr", 32'(dcache_addr), 32'h40);
        tick();
        chk("mis_pending", 32'(misalign_o), 32'h0);
        dcache_stall = 1'b0;
        tick();
        chk("mis_flag",    32'(misalign_o), 32'h1);
        chk("mis_wb_data", wb_data, 32'h11);
        clr();
        tick();
        chk("mis_clear", 32'(misalign_o), 32'h0);
        chk("mis_cnt",   32'(stall_cycles_o), 32'h4);

        // Reset while a request is outstanding
        memrd_in = 1'b1; mem2reg_in = 1'b1; regwr_in = 1'b1; rd_in = 5'd6;
        alu_result_in = 32'h400; dcache_stall = 1'b1;
        tick();
        chk("rq_stall_o", 32'(stall_o), 32'h1);
        chk("rq_cnt",     32'(stall_cycles_o), 32'h5);
        rst_n = 1'b0;
        clr();
        tick();
        chk("rr_wb_data",  wb_data, 32'h0);
        chk("rr_wb_rd",    32'(wb_rd), 32'h0);
        chk("rr_wb_regwr", 32'(wb_regwr), 32'h0);
        chk("rr_misalign", 32'(misalign_o), 32'h0);
        chk("rr_cnt",      32'(stall_cycles_o), 32'h0);
        chk("rr_stall_o",  32'(stall_o), 32'h0);
        rst_n = 1'b1;
        memrd_in = 1'b1; alu_result_in = 32'h500;
        settle();
        chk("rr_ren_idle", 32'(dcache_ren), 32'h1);
        tick();
        clr();

        // Stall counter saturation
        memrd_in = 1'b1; alu_result_in = 32'h600; dcache_stall = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        #1;
        chk("sat_cnt", 32'(stall_cycles_o), 32'hFFFF);
        chk("sat_stall_o", 32'(stall_o), 32'h1);
        tick();
        chk("sat_cnt_hold", 32'(stall_cycles_o), 32'hFFFF);
        clr();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage; consumes its registered EX/MEM outputs.
- Issues the data-cache read/write and holds the pipeline while the cache is busy.
- Selects write-back data and registers the MEM/WB pipeline outputs.
- Provides combinational MEM-stage forwarding data back to execute, guarantees each store/load is issued to the cache exactly once even under external freeze, and counts cache-stall cycles.

Parameters:
BIT_W, 32, datapath width
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
alu_result_in  in  BIT_W  ALU result / memory byte address from EX
mem_wdata_in  in  BIT_W  store data from EX
rd_in  in  5  destination register
PC_step_in  in  BIT_W  PC+2/PC+4 link value
memrd_in  in  1  load
memwr_in  in  1  store
mem2reg_in  in  1  write-back selects load data
regwr_in  in  1  register write enable
jump_in  in  1  jal/jalr; write-back selects PC_step_in
stall_in  in  1  freeze request from elsewhere in pipeline
dcache_ren  out  1  cache read request
dcache_wen  out  1  cache write request
dcache_addr  out  BIT_W-2  word address = alu_result_in[BIT_W-1:2]
dcache_wdata  out  BIT_W  = mem_wdata_in
dcache_rdata  in  BIT_W  load data, valid in completion cycle
dcache_stall  in  1  cache busy; request must stay stable while high
stall_o  out  1  cache stall, freezes IF/ID/EX
wb_data  out  BIT_W  registered write-back data
wb_rd  out  5  registered destination
wb_regwr  out  1  registered write enable
fwd_valid_o  out  1  MEM-stage forward available
fwd_rd_o  out  5  forward destination
fwd_data_o  out  BIT_W  forward data
misalign_o  out  1  registered one-cycle flag: misaligned access completed
stall_cycles_o  out  CNT_W  saturating count of stall_o-high cycles

Behaviour:
- States: IDLE, REQ (cache stall seen, request outstanding), HOLD (access completed, frozen by stall_in, result buffered).
- Definitions:
  - acc = memrd_in | memwr_in.
  - mem_req = acc & (state != HOLD).
  - dcache_ren = memrd_in & (state != HOLD); dcache_wen = memwr_in & (state != HOLD).
  - complete = mem_req & !dcache_stall.
- stall_o = mem_req & dcache_stall (combinational).
- freeze = stall_o | stall_in.
- Upstream holds inputs stable while freeze is high.
- Transitions:
  - IDLE -> REQ: mem_req & dcache_stall.
  - IDLE/REQ -> HOLD: complete & stall_in; dcache_rdata is latched into load_buf.
  - REQ -> IDLE: complete & !stall_in.
  - HOLD -> IDLE: !stall_in.
  - Otherwise stay in the current state.
- Write-back select, priority order:
  - mem2reg_in: (state==HOLD ? load_buf : dcache_rdata).
  - else jump_in: PC_step_in.
  - else alu_result_in.
- MEM/WB register update, per clock:
  - stall_in=1: hold all wb_* values.
  - stall_o=1 & stall_in=0: bubble, wb_regwr<=0; wb_data and wb_rd hold.
  - Otherwise: load the selected data and rd_in; wb_regwr <= regwr_in & (rd_in != 0).
- Forwarding (combinational):
  - fwd_valid_o = regwr_in & !mem2reg_in & (rd_in != 0).
  - fwd_rd_o = rd_in.
  - fwd_data_o = jump_in ? PC_step_in : alu_result_in.
  - Loads never forward from this stage; the hazard unit stalls for them.
- Misaligned access (alu_result_in[1:0] != 0 with acc):
  - The access is still issued at the word address.
  - misalign_o = 1 for the one cycle after complete; 0 otherwise.
- stall_cycles_o: increments each cycle stall_o=1; saturates at all-ones; no wrap.
- Stores are never re-issued:
  - After completion under stall_in, state HOLD masks dcache_wen/dcache_ren until stall_in drops.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; load_buf, wb_data, wb_rd, wb_regwr, misalign_o, stall_cycles_o all 0.
  - Holds mid-REQ or mid-HOLD; the outstanding request is abandoned.
- Zero-wait cache (dcache_stall never high): 1-cycle latency input->wb_*, stall_o always 0.

Test Plan:
- ALU op: alu_result_in=0x1234, regwr_in=1, rd_in=5, no stall -> next cycle wb_data=0x1234, wb_rd=5, wb_regwr=1; fwd_valid_o=1 in the same cycle.
- Load, 3 stall cycles: memrd_in=1, addr 0x100, dcache_stall high 3 cycles, rdata=0xCAFEBABE -> stall_o high 3 cycles, dcache_addr=0x40, wb_regwr=0 during stall, then wb_data=0xCAFEBABE; stall_cycles_o=3.
- Store under freeze: memwr_in=1 completes while stall_in=1 for 4 cycles -> dcache_wen high exactly 1 cycle, state HOLD for 4 cycles, wb_* held.
- Load under freeze: load completes with rdata=0xA5A5A5A5 and stall_in=1, then rdata changes to 0 -> after stall_in falls, wb_data=0xA5A5A5A5.
- jal: jump_in=1, PC_step_in=0x208, rd_in=1 -> wb_data=0x208 and fwd_data_o=0x208; rd_in=0 -> wb_regwr=0, fwd_valid_o=0.
- Reset and misalign: rst_n=0 during REQ -> state IDLE, all outputs 0 next cycle. Misaligned addr 0x102 load -> misalign_o=1 for one cycle after completion. Counter forced to 0xFFFF -> remains 0xFFFF.
